// File: rtl/iob_ram_1rw1r_sync.sv
// iob_ram_1rw1r_sync: single-clock RAM with one read/write port (A) and one
// read-only port (B). Byte-lane write strobes, write-first forwarding from an
// A write to a B read of the same address, and a hardware clear of every word
// after reset. The clear takes DEPTH cycles; init_done goes high when it ends.
// Optional macro IOB_RAM_OUTREG_EN adds an output register stage on both
// ports, which makes the read latency 2 cycles instead of 1.
// Request semantics: a_en/b_en are single-cycle requests with no ready signal.
// Every request sampled in READY gets exactly one rvalid pulse after the read
// latency. Requests sampled during CLEAR are dropped.
module iob_ram_1rw1r_sync #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [STRB_W-1:0] a_wstrb,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid
);

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
    logic                w_clr_we;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_ready;
    logic                w_a_in_rng, w_b_in_rng;
    logic                w_a_wr, w_a_rd, w_b_rd;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [STRB_W-1:0]   w_mem_strb;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_a_rd_word, w_b_old, w_b_rd_word;
    logic                w_coll;

    logic [DATA_W-1:0]   r_a_rdata, r_b_rdata;
    logic                r_a_rvalid, r_b_rvalid;

    assign w_ready   = (r_state == ST_READY);
    assign init_done = w_ready;

    // State register and clear-address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next state: walk every address once writing zero, then go to READY.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_cnt == LP_LAST) begin
                    w_state_nxt   = ST_READY;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
    assign w_a_in_rng = ({1'b0, a_addr} < LP_DEPTH);
    assign w_b_in_rng = ({1'b0, b_addr} < LP_DEPTH);

    assign w_a_wr = w_ready & a_en & a_we & w_a_in_rng;
    assign w_a_rd = w_ready & a_en & ~a_we;
    assign w_b_rd = w_ready & b_en;

    // The clear sequence and port A share the single write port of the array.
    assign w_mem_we    = ~rst & (w_clr_we | w_a_wr);
    assign w_mem_addr  = w_clr_we ? r_clr_cnt : a_addr;
    assign w_mem_strb  = w_clr_we ? {STRB_W{1'b1}} : a_wstrb;
    assign w_mem_wdata = w_clr_we ? '0 : a_wdata;

    // Array write with per-byte enables; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_mem_strb[i]) begin
                    r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_a_rd_word = w_a_in_rng ? r_mem[a_addr] : '0;
    assign w_b_old     = w_b_in_rng ? r_mem[b_addr] : '0;
    assign w_coll      = w_a_wr & (a_addr == b_addr);

    // Write-first: on a collision B sees the strobed lanes of the A write.
    always_comb begin
        w_b_rd_word = w_b_old;
        if (w_coll) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (a_wstrb[i]) begin
                    w_b_rd_word[8*i +: 8] = a_wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: data is loaded only on a read, so it holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rdata  <= '0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_rd;
            r_b_rvalid <= w_b_rd;
            if (w_a_rd) begin
                r_a_rdata <= w_a_rd_word;
            end
            if (w_b_rd) begin
                r_b_rdata <= w_b_rd_word;
            end
        end
    end

`ifdef IOB_RAM_OUTREG_EN
    logic [DATA_W-1:0] r_a_rdata_q, r_b_rdata_q;
    logic              r_a_rvalid_q, r_b_rvalid_q;

    // Extra output stage: forwards the first stage unchanged one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_rdata_q  <= '0;
            r_a_rvalid_q <= 1'b0;
            r_b_rdata_q  <= '0;
            r_b_rvalid_q <= 1'b0;
        end else begin
            r_a_rvalid_q <= r_a_rvalid;
            r_b_rvalid_q <= r_b_rvalid;
            if (r_a_rvalid) begin
                r_a_rdata_q <= r_a_rdata;
            end
            if (r_b_rvalid) begin
                r_b_rdata_q <= r_b_rdata;
            end
        end
    end

    assign a_rdata  = r_a_rdata_q;
    assign a_rvalid = r_a_rvalid_q;
    assign b_rdata  = r_b_rdata_q;
    assign b_rvalid = r_b_rvalid_q;
`else
    assign a_rdata  = r_a_rdata;
    assign a_rvalid = r_a_rvalid;
    assign b_rdata  = r_b_rdata;
    assign b_rvalid = r_b_rvalid;
`endif

endmodule

// File: tb/tb_iob_ram_1rw1r_sync.sv
// Bench for iob_ram_1rw1r_sync: a default 32x512 instance and a 64x300
// instance (non-power-of-two depth) share clock and reset. Expected read data
// and the cycle it is due are queued when a read is issued and popped when
// rvalid is seen.
module tb_iob_ram_1rw1r_sync;

`ifdef IOB_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk, rst;
    logic        init_done;
    logic        a_en, a_we;
    logic [3:0]  a_wstrb;
    logic [8:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        a_rvalid;
    logic        b_en;
    logic [8:0]  b_addr;
    logic [31:0] b_rdata;
    logic        b_rvalid;

    logic        d2_init_done;
    logic        d2_a_en, d2_a_we;
    logic [7:0]  d2_a_wstrb;
    logic [8:0]  d2_a_addr;
    logic [63:0] d2_a_wdata, d2_a_rdata;
    logic        d2_a_rvalid;
    logic        d2_b_en;
    logic [8:0]  d2_b_addr;
    logic [63:0] d2_b_rdata;
    logic        d2_b_rvalid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] exp_a_q[$], exp_b_q[$];
    logic [63:0] exp_c_q[$], exp_d_q[$];
    int          due_a_q[$], due_b_q[$], due_c_q[$], due_d_q[$];
    logic [31:0] m1 [512];

    iob_ram_1rw1r_sync u_dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .a_en(a_en), .a_we(a_we), .a_wstrb(a_wstrb), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
    );

    iob_ram_1rw1r_sync #(.DATA_W(64), .DEPTH(300)) u_dut2 (
        .clk(clk), .rst(rst), .init_done(d2_init_done),
        .a_en(d2_a_en), .a_we(d2_a_we), .a_wstrb(d2_a_wstrb), .a_addr(d2_a_addr),
        .a_wdata(d2_a_wdata), .a_rdata(d2_a_rdata), .a_rvalid(d2_a_rvalid),
        .b_en(d2_b_en), .b_addr(d2_b_addr), .b_rdata(d2_b_rdata), .b_rvalid(d2_b_rvalid)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clk_step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_en = 1'b0; a_we = 1'b0; a_wstrb = '0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_addr = '0;
        d2_a_en = 1'b0; d2_a_we = 1'b0; d2_a_wstrb = '0; d2_a_addr = '0;
        d2_a_wdata = '0; d2_b_en = 1'b0; d2_b_addr = '0;
    endtask

    // Port A write on the default instance; the reference model is updated too.
    task automatic a_write(input logic [8:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_wstrb = strb;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) m1[addr][8*i +: 8] = data[8*i +: 8];
        end
        clk_step;
        a_en = 1'b0; a_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle();
        repeat (3) clk_step;
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_a_rvalid: got %b want 0", a_rvalid); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_b_rvalid: got %b want 0", b_rvalid); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_a_rdata: got %h want 0", a_rdata); end
        checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL rst_b_rdata: got %h want 0", b_rdata); end
        checks++; if (d2_init_done !== 1'b0) begin errors++; $display("FAIL rst_d2_init_done: got %b want 0", d2_init_done); end
    endtask

    // Release reset with port A reading throughout; count edges to init_done.
    task automatic test_clear;
        int  n;
        bit  early;
        logic [31:0] d;
        int  t;
        for (int i = 0; i < 512; i++) m1[i] = 32'h0;
        a_en = 1'b1; a_we = 1'b0; a_addr = 9'd0;
        rst = 1'b0;
        n = 0; early = 1'b0;
        while (n < 600) begin
            clk_step;
            n++;
            if (a_rvalid) early = 1'b1;
            if (init_done) break;
        end
        a_en = 1'b0;
        checks++; if (n != 512) begin errors++; $display("FAIL clear_time: init_done after %0d cycles want 512", n); end
        checks++; if (early) begin errors++; $display("FAIL clear_drop: a_rvalid seen during clear, want none"); end
        for (int c = 0; c < 2 + LAT + 1; c++) begin
            idle();
            if (c < 2) begin
                a_en = 1'b1; a_addr = (c == 0) ? 9'd0 : 9'd511;
                b_en = 1'b1; b_addr = (c == 0) ? 9'd511 : 9'd0;
                exp_a_q.push_back(32'h0); due_a_q.push_back(cyc + LAT);
                exp_b_q.push_back(32'h0); due_b_q.push_back(cyc + LAT);
            end
            clk_step;
            if (a_rvalid) begin
                checks++;
                if (exp_a_q.size() == 0) begin errors++; $display("FAIL clear_a_rd: unexpected a_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_a_q.pop_front(); t = due_a_q.pop_front();
                    if (a_rdata !== d || cyc != t) begin errors++; $display("FAIL clear_a_rd: got %h at cycle %0d want %h at cycle %0d", a_rdata, cyc, d, t); end
                end
            end
            if (b_rvalid) begin
                checks++;
                if (exp_b_q.size() == 0) begin errors++; $display("FAIL clear_b_rd: unexpected b_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_b_q.pop_front(); t = due_b_q.pop_front();
                    if (b_rdata !== d || cyc != t) begin errors++; $display("FAIL clear_b_rd: got %h at cycle %0d want %h at cycle %0d", b_rdata, cyc, d, t); end
                end
            end
        end
        checks++; if (exp_a_q.size() + exp_b_q.size() != 0) begin errors++; $display("FAIL clear_pending: %0d reads outstanding want 0", exp_a_q.size() + exp_b_q.size()); end
        exp_a_q.delete(); due_a_q.delete(); exp_b_q.delete(); due_b_q.delete();
    endtask

    task automatic test_byte_strobes;
        logic [31:0] d;
        int t;
        a_write(9'd5, 32'hAABBCCDD, 4'b1111);
        a_write(9'd5, 32'h11223344, 4'b0101);
        a_write(9'd5, 32'h99999999, 4'b0000);
        for (int c = 0; c < 1 + LAT + 1; c++) begin
            idle();
            if (c == 0) begin
                a_en = 1'b1; a_addr = 9'd5; b_en = 1'b1; b_addr = 9'd5;
                exp_a_q.push_back(32'hAA22CC44); due_a_q.push_back(cyc + LAT);
                exp_b_q.push_back(32'hAA22CC44); due_b_q.push_back(cyc + LAT);
            end
            clk_step;
            if (a_rvalid) begin
                checks++;
                if (exp_a_q.size() == 0) begin errors++; $display("FAIL strb_a_rd: unexpected a_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_a_q.pop_front(); t = due_a_q.pop_front();
                    if (a_rdata !== d || cyc != t) begin errors++; $display("FAIL strb_a_rd: got %h at cycle %0d want %h at cycle %0d", a_rdata, cyc, d, t); end
                end
            end
            if (b_rvalid) begin
                checks++;
                if (exp_b_q.size() == 0) begin errors++; $display("FAIL strb_b_rd: unexpected b_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_b_q.pop_front(); t = due_b_q.pop_front();
                    if (b_rdata !== d || cyc != t) begin errors++; $display("FAIL strb_b_rd: got %h at cycle %0d want %h at cycle %0d", b_rdata, cyc, d, t); end
                end
            end
        end
        checks++; if (exp_a_q.size() + exp_b_q.size() != 0) begin errors++; $display("FAIL strb_pending: %0d reads outstanding want 0", exp_a_q.size() + exp_b_q.size()); end
        exp_a_q.delete(); due_a_q.delete(); exp_b_q.delete(); due_b_q.delete();
    endtask

    // A write and B read of the same word in one cycle, then A reads it back.
    task automatic test_collision;
        logic [31:0] d;
        int t;
        a_write(9'd9, 32'h12345678, 4'b1111);
        for (int c = 0; c < 2 + LAT + 1; c++) begin
            idle();
            if (c == 0) begin
                a_en = 1'b1; a_we = 1'b1; a_addr = 9'd9; a_wdata = 32'hFFFFFFFF; a_wstrb = 4'b0011;
                b_en = 1'b1; b_addr = 9'd9;
                m1[9] = 32'h1234FFFF;
                exp_b_q.push_back(32'h1234FFFF); due_b_q.push_back(cyc + LAT);
            end else if (c == 1) begin
                a_en = 1'b1; a_addr = 9'd9;
                exp_a_q.push_back(32'h1234FFFF); due_a_q.push_back(cyc + LAT);
            end
            clk_step;
            if (a_rvalid) begin
                checks++;
                if (exp_a_q.size() == 0) begin errors++; $display("FAIL coll_a_rd: unexpected a_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_a_q.pop_front(); t = due_a_q.pop_front();
                    if (a_rdata !== d || cyc != t) begin errors++; $display("FAIL coll_a_rd: got %h at cycle %0d want %h at cycle %0d", a_rdata, cyc, d, t); end
                end
            end
            if (b_rvalid) begin
                checks++;
                if (exp_b_q.size() == 0) begin errors++; $display("FAIL coll_b_rd: unexpected b_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_b_q.pop_front(); t = due_b_q.pop_front();
                    if (b_rdata !== d || cyc != t) begin errors++; $display("FAIL coll_b_rd: got %h at cycle %0d want %h at cycle %0d", b_rdata, cyc, d, t); end
                end
            end
        end
        checks++; if (exp_a_q.size() + exp_b_q.size() != 0) begin errors++; $display("FAIL coll_pending: %0d reads outstanding want 0", exp_a_q.size() + exp_b_q.size()); end
        exp_a_q.delete(); due_a_q.delete(); exp_b_q.delete(); due_b_q.delete();
    endtask

    // A reads 0..7 while B reads 7..0, one request per cycle on each port.
    task automatic test_back_to_back;
        logic [31:0] d;
        int t;
        for (int i = 0; i < 8; i++) a_write(9'(i), $urandom(), 4'b1111);
        for (int c = 0; c < 8 + LAT + 1; c++) begin
            idle();
            if (c < 8) begin
                a_en = 1'b1; a_addr = 9'(c);
                b_en = 1'b1; b_addr = 9'(7 - c);
                exp_a_q.push_back(m1[c]);     due_a_q.push_back(cyc + LAT);
                exp_b_q.push_back(m1[7 - c]); due_b_q.push_back(cyc + LAT);
            end
            clk_step;
            if (a_rvalid) begin
                checks++;
                if (exp_a_q.size() == 0) begin errors++; $display("FAIL b2b_a_rd: unexpected a_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_a_q.pop_front(); t = due_a_q.pop_front();
                    if (a_rdata !== d || cyc != t) begin errors++; $display("FAIL b2b_a_rd: got %h at cycle %0d want %h at cycle %0d", a_rdata, cyc, d, t); end
                end
            end
            if (b_rvalid) begin
                checks++;
                if (exp_b_q.size() == 0) begin errors++; $display("FAIL b2b_b_rd: unexpected b_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_b_q.pop_front(); t = due_b_q.pop_front();
                    if (b_rdata !== d || cyc != t) begin errors++; $display("FAIL b2b_b_rd: got %h at cycle %0d want %h at cycle %0d", b_rdata, cyc, d, t); end
                end
            end
        end
        checks++; if (exp_a_q.size() + exp_b_q.size() != 0) begin errors++; $display("FAIL b2b_pending: %0d reads outstanding want 0", exp_a_q.size() + exp_b_q.size()); end
        exp_a_q.delete(); due_a_q.delete(); exp_b_q.delete(); due_b_q.delete();
        clk_step;
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== m1[7]) begin errors++; $display("FAIL b2b_a_hold: got %b/%h want 0/%h", a_rvalid, a_rdata, m1[7]); end
        checks++; if (b_rvalid !== 1'b0 || b_rdata !== m1[0]) begin errors++; $display("FAIL b2b_b_hold: got %b/%h want 0/%h", b_rvalid, b_rdata, m1[0]); end
    endtask

    // Reset one cycle after a read request, then again at clear counter 100.
    task automatic test_reset_mid;
        int  n;
        bit  early;
        logic [31:0] d;
        int  t;
        idle();
        a_en = 1'b1; a_addr = 9'd3; b_en = 1'b1; b_addr = 9'd4;
        clk_step;
        idle();
        #2 rst = 1'b1;
        #1;
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin errors++; $display("FAIL rstrd_a: got %b/%h want 0/0", a_rvalid, a_rdata); end
        checks++; if (b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin errors++; $display("FAIL rstrd_b: got %b/%h want 0/0", b_rvalid, b_rdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rstrd_init_done: got %b want 0", init_done); end
        repeat (3) clk_step;
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rstrd_discard: rvalid %b/%b want 0/0", a_rvalid, b_rvalid); end
        rst = 1'b0;
        a_en = 1'b1; a_addr = 9'd3;
        repeat (100) clk_step;
        #3 rst = 1'b1;
        #1;
        checks++; if (init_done !== 1'b0 || a_rvalid !== 1'b0) begin errors++; $display("FAIL rstclr_out: init_done/a_rvalid %b/%b want 0/0", init_done, a_rvalid); end
        clk_step;
        rst = 1'b0;
        for (int i = 0; i < 512; i++) m1[i] = 32'h0;
        n = 0; early = 1'b0;
        while (n < 600) begin
            clk_step;
            n++;
            if (a_rvalid) early = 1'b1;
            if (init_done) break;
        end
        a_en = 1'b0;
        checks++; if (n != 512) begin errors++; $display("FAIL rstclr_time: init_done after %0d cycles want 512", n); end
        checks++; if (early) begin errors++; $display("FAIL rstclr_drop: a_rvalid seen during clear, want none"); end
        for (int c = 0; c < 1 + LAT + 1; c++) begin
            idle();
            if (c == 0) begin
                a_en = 1'b1; a_addr = 9'd3;
                exp_a_q.push_back(32'h0); due_a_q.push_back(cyc + LAT);
            end
            clk_step;
            if (a_rvalid) begin
                checks++;
                if (exp_a_q.size() == 0) begin errors++; $display("FAIL rstclr_a_rd: unexpected a_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_a_q.pop_front(); t = due_a_q.pop_front();
                    if (a_rdata !== d || cyc != t) begin errors++; $display("FAIL rstclr_a_rd: got %h at cycle %0d want %h at cycle %0d", a_rdata, cyc, d, t); end
                end
            end
        end
        checks++; if (exp_a_q.size() != 0) begin errors++; $display("FAIL rstclr_pending: %0d reads outstanding want 0", exp_a_q.size()); end
        exp_a_q.delete(); due_a_q.delete();
    endtask

    // 64x300 instance: address 310 is out of range, 299 is the last word.
    task automatic test_depth300;
        logic [63:0] v, d;
        int t;
        v = {$urandom(), $urandom()};
        checks++; if (d2_init_done !== 1'b1) begin errors++; $display("FAIL d2_init_done: got %b want 1", d2_init_done); end
        for (int c = 0; c < 4 + LAT + 1; c++) begin
            idle();
            case (c)
                0: begin
                    d2_a_en = 1'b1; d2_a_we = 1'b1; d2_a_addr = 9'd310;
                    d2_a_wdata = 64'hFFFF_FFFF_FFFF_FFFF; d2_a_wstrb = 8'hFF;
                    d2_b_en = 1'b1; d2_b_addr = 9'd310;
                    exp_d_q.push_back(64'h0); due_d_q.push_back(cyc + LAT);
                end
                1: begin
                    d2_a_en = 1'b1; d2_a_we = 1'b1; d2_a_addr = 9'd299;
                    d2_a_wdata = v; d2_a_wstrb = 8'hFF;
                    d2_b_en = 1'b1; d2_b_addr = 9'd54;
                    exp_d_q.push_back(64'h0); due_d_q.push_back(cyc + LAT);
                end
                2: begin
                    d2_a_en = 1'b1; d2_a_addr = 9'd310;
                    exp_c_q.push_back(64'h0); due_c_q.push_back(cyc + LAT);
                    d2_b_en = 1'b1; d2_b_addr = 9'd299;
                    exp_d_q.push_back(v); due_d_q.push_back(cyc + LAT);
                end
                3: begin
                    d2_a_en = 1'b1; d2_a_addr = 9'd299;
                    exp_c_q.push_back(v); due_c_q.push_back(cyc + LAT);
                    d2_b_en = 1'b1; d2_b_addr = 9'd0;
                    exp_d_q.push_back(64'h0); due_d_q.push_back(cyc + LAT);
                end
                default: ;
            endcase
            clk_step;
            if (d2_a_rvalid) begin
                checks++;
                if (exp_c_q.size() == 0) begin errors++; $display("FAIL d2_a_rd: unexpected a_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_c_q.pop_front(); t = due_c_q.pop_front();
                    if (d2_a_rdata !== d || cyc != t) begin errors++; $display("FAIL d2_a_rd: got %h at cycle %0d want %h at cycle %0d", d2_a_rdata, cyc, d, t); end
                end
            end
            if (d2_b_rvalid) begin
                checks++;
                if (exp_d_q.size() == 0) begin errors++; $display("FAIL d2_b_rd: unexpected b_rvalid at cycle %0d", cyc); end
                else begin
                    d = exp_d_q.pop_front(); t = due_d_q.pop_front();
                    if (d2_b_rdata !== d || cyc != t) begin errors++; $display("FAIL d2_b_rd: got %h at cycle %0d want %h at cycle %0d", d2_b_rdata, cyc, d, t); end
                end
            end
        end
        checks++; if (exp_c_q.size() + exp_d_q.size() != 0) begin errors++; $display("FAIL d2_pending: %0d reads outstanding want 0", exp_c_q.size() + exp_d_q.size()); end
        exp_c_q.delete(); due_c_q.delete(); exp_d_q.delete(); due_d_q.delete();
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_strobes();
        test_collision();
        test_back_to_back();
        test_depth300();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob_ram_1rw1r_sync.md
Name: iob_ram_1rw1r_sync

Overview:
- Parametrised single-clock dual-port SRAM block: one read/write port (A), one read-only port (B).
- Byte-lane write strobes, write-first forwarding to port B on address collision, and a post-reset hardware clear sequence.
- Sits as the generic on-chip memory for SoC data/program RAM and crypto-accelerator buffers wherever width/depth differ from the fixed 32x512 hard macro.
- Single clock domain, behavioural array, synthesisable for FPGA and simulation.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 512, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), address width.
- STRB_W, DATA_W/8, number of byte write strobes (derived, not overridable).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- init_done  out  1  high once the post-reset clear has finished
- a_en  in  1  port A request valid
- a_we  in  1  port A write (1) / read (0)
- a_wstrb  in  STRB_W  port A byte write enables
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data
- a_rvalid  out  1  port A read data valid pulse
- b_en  in  1  port B read request
- b_addr  in  ADDR_W  port B address
- b_rdata  out  DATA_W  port B read data
- b_rvalid  out  1  port B read data valid pulse

Behaviour:
- Reset values: init_done=0, a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0. FSM enters CLEAR; clear counter=0.
- FSM states:
  - CLEAR: writes 0 to address counter each cycle, counter+1. After writing DEPTH-1, go to READY and set init_done=1 on that edge.
  - READY: normal operation. Total clear time is DEPTH cycles after reset deassertion.
- Requests during CLEAR (a_en/b_en high) are dropped: no write, no rvalid.
- rst asserted mid-operation (any state): outputs return to reset values immediately; in-flight reads are discarded; CLEAR restarts at address 0.
- Port A write (a_en=1, a_we=1):
  - For each lane i with a_wstrb[i]=1, mem[a_addr][8i+7:8i] <= a_wdata[8i+7:8i].
  - a_wstrb=0 leaves memory unchanged.
  - No a_rvalid; a_rdata holds its previous value.
- Port A read (a_en=1, a_we=0): a_rdata=mem[a_addr] and a_rvalid=1 one cycle after the request edge (latency 1). a_rvalid is a single-cycle pulse per request; back-to-back reads give back-to-back pulses.
- Port B read (b_en=1): same timing as a port A read.
- Data hold: a_rdata/b_rdata hold the last read value until the next read completes (not cleared when rvalid falls).
- Collision (A write and B read to the same address, same cycle): write-first. b_rdata = old word with strobed lanes replaced by a_wdata; unstrobed lanes keep old data.
- Port A read of an address written in the previous cycle returns the new data (array already updated).
- Out-of-range address (addr >= DEPTH, non-power-of-two DEPTH only):
  - Writes are ignored.
  - Reads return 0 with rvalid asserted normally.
- a_en and b_en are independent; both may fire every cycle. No backpressure.

Optional Feature:
- Macro IOB_RAM_OUTREG_EN.
- Defined: an extra output register stage on both ports.
  - Read latency becomes 2 cycles.
  - rvalid is delayed to match.
  - Collision forwarding result is carried through the extra stage unchanged.
  - Reset clears the extra stage to 0 / rvalid 0.
- Undefined: latency 1, as described in Behaviour.

Test Plan:
- Clear check: deassert rst, hold a_en=1 a_we=0 throughout. init_done rises exactly 512 cycles after reset release; no a_rvalid before that. Then read addr 0, 511 -> 0x00000000, each with a_rvalid one cycle later.
- Byte strobes: write 0xAABBCCDD to addr 5 with wstrb=4'b1111, then 0x11223344 with wstrb=4'b0101. Read addr 5 -> 0xAA22CC44 on both ports.
- Collision forwarding: mem[9]=0x12345678. Same cycle: A writes 0xFFFFFFFF with wstrb=4'b0011 to 9, B reads 9. b_rdata=0x1234FFFF next cycle.
- Back-to-back dual read: A reads addrs 0..7 and B reads 7..0 on consecutive cycles. Eight consecutive rvalid pulses per port with the correct pattern data; data held after the last pulse.
- Reset mid-clear and mid-read: assert rst at clear counter 100, and again one cycle after a read request. Outputs go to 0 asynchronously; no rvalid; CLEAR restarts and init_done rises 512 cycles after release.
- Non-power-of-two and outreg: DEPTH=300, DATA_W=64, IOB_RAM_OUTREG_EN defined. Write to addr 310 ignored; read 310 -> 0 with rvalid. Read of a valid address shows 2-cycle latency.
